// File: rtl/gene_pkg.sv
// Shared definitions for the 8-gene Boolean network stepper and its rule logic.
// The rule function is kept here so future network variants share a single definition.
package gene_pkg;

   localparam int GENE_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // One network update: gene 0 is repressed by gene 7, genes 1..6 form a shift chain,
   // gene 7 is activated by gene 6 and repressed by gene 3.
   function automatic logic [GENE_W-1:0] gene_next(input logic [GENE_W-1:0] x);
      logic [GENE_W-1:0] n;
      n    = {x[GENE_W-2:0], 1'b0};
      n[0] = ~x[7];
      n[7] = x[6] & ~x[3];
      return n;
   endfunction

endpackage

// File: rtl/gene_rule.sv
// Combinational network update n = f(x).
module gene_rule
   import gene_pkg::*;
(
   input  logic [GENE_W-1:0] x,
   output logic [GENE_W-1:0] n
);

   assign n = gene_next(x);

endmodule

// File: rtl/gene_step.sv
// Boolean network stepper: latches an initial state on load, then advances one
// network update per enabled clock until a fixed point or the step budget is reached.
module gene_step
   import gene_pkg::*;
#(
   parameter int MAX_STEPS = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [GENE_W-1:0] init,
   input  logic              load,
   input  logic              step_en,
   output logic [GENE_W-1:0] x,
   output logic              x_valid,
   output logic [GENE_W-1:0] init_q,
   output logic [7:0]        step_cnt,
   output logic              busy,
   output logic              done,
   output logic              fixed,
   output logic              timeout
);

   localparam logic [7:0] MAX_CNT = 8'(MAX_STEPS);

   state_t            state_reg,   state_next;
   logic [GENE_W-1:0] x_reg,       x_next;
   logic [GENE_W-1:0] init_q_reg,  init_q_next;
   logic [7:0]        cnt_reg,     cnt_next;
   logic              valid_reg,   valid_next;
   logic              busy_reg,    busy_next;
   logic              done_reg,    done_next;
   logic              fixed_reg,   fixed_next;
   logic              timeout_reg, timeout_next;
   logic [GENE_W-1:0] x_rule;

   gene_rule u_rule (
      .x (x_reg),
      .n (x_rule)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= S_IDLE;
         x_reg       <= '0;
         init_q_reg  <= '0;
         cnt_reg     <= '0;
         valid_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         fixed_reg   <= 1'b0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         x_reg       <= x_next;
         init_q_reg  <= init_q_next;
         cnt_reg     <= cnt_next;
         valid_reg   <= valid_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         fixed_reg   <= fixed_next;
         timeout_reg <= timeout_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      x_next       = x_reg;
      init_q_next  = init_q_reg;
      cnt_next     = cnt_reg;
      valid_next   = 1'b0;
      done_next    = done_reg;
      fixed_next   = fixed_reg;
      timeout_next = timeout_reg;

      if (load) begin
         x_next       = init;
         init_q_next  = init;
         cnt_next     = '0;
         valid_next   = 1'b1;
         done_next    = 1'b0;
         fixed_next   = 1'b0;
         timeout_next = 1'b0;
         state_next   = S_RUN;
      end else begin
         case (state_reg)
            S_RUN: begin
               if (step_en) begin
                  // Fixed point outranks the budget so a settled trajectory is never reported as a timeout.
                  if (x_rule == x_reg) begin
                     fixed_next = 1'b1;
                     done_next  = 1'b1;
                     state_next = S_DONE;
                  end else if (cnt_reg == MAX_CNT) begin
                     timeout_next = 1'b1;
                     done_next    = 1'b1;
                     state_next   = S_DONE;
                  end else begin
                     x_next     = x_rule;
                     cnt_next   = 8'(cnt_reg + 8'd1);
                     valid_next = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      busy_next = (state_next == S_RUN);
   end

   assign x        = x_reg;
   assign x_valid  = valid_reg;
   assign init_q   = init_q_reg;
   assign step_cnt = cnt_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign fixed    = fixed_reg;
   assign timeout  = timeout_reg;

endmodule

// File: tb/tb_gene_step.sv
// Table-driven bench for gene_step: three instances (budgets 255, 3, 1) share clock and reset;
// produced states are also checked through a scoreboard queue popped on each x_valid pulse.
module tb_gene_step;

   typedef struct {
      int         d;
      logic       ld;
      logic [7:0] ini;
      logic       en;
      logic [7:0] ex;
      logic       ev;
      logic [7:0] ec;
      logic [7:0] eq;
      logic [3:0] fl;   // {busy, done, fixed, timeout}
   } vec_t;

   logic       clk;
   logic       rst;
   logic       load_s    [3];
   logic [7:0] init_s    [3];
   logic       en_s      [3];
   logic [7:0] x_s       [3];
   logic       valid_s   [3];
   logic [7:0] initq_s   [3];
   logic [7:0] cnt_s     [3];
   logic       busy_s    [3];
   logic       done_s    [3];
   logic       fixed_s   [3];
   logic       timeout_s [3];

   int n_cmp = 0;
   int n_bad = 0;
   logic [17:0] sbq[$];
   vec_t tbl[$];

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      gene_step #(.MAX_STEPS(gi == 0 ? 255 : (gi == 1 ? 3 : 1))) u_dut (
         .clk      (clk),
         .rst      (rst),
         .init     (init_s[gi]),
         .load     (load_s[gi]),
         .step_en  (en_s[gi]),
         .x        (x_s[gi]),
         .x_valid  (valid_s[gi]),
         .init_q   (initq_s[gi]),
         .step_cnt (cnt_s[gi]),
         .busy     (busy_s[gi]),
         .done     (done_s[gi]),
         .fixed    (fixed_s[gi]),
         .timeout  (timeout_s[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input int d, input logic ld, input logic [7:0] ini, input logic en,
                               input logic [7:0] ex, input logic ev, input logic [7:0] ec,
                               input logic [7:0] eq, input logic [3:0] fl);
      vec_t v;
      v.d = d; v.ld = ld; v.ini = ini; v.en = en;
      v.ex = ex; v.ev = ev; v.ec = ec; v.eq = eq; v.fl = fl;
      return v;
   endfunction

   task automatic clear_inputs();
      for (int k = 0; k < 3; k++) begin
         load_s[k] = 1'b0;
         en_s[k]   = 1'b0;
         init_s[k] = 8'h00;
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      clear_inputs();
      load_s[v.d] = v.ld;
      init_s[v.d] = v.ini;
      en_s[v.d]   = v.en;
      if (v.ev) sbq.push_back({2'(v.d), v.ex, v.ec});
      @(posedge clk);
      #1;
      chk({tag, " x"},       {24'd0, x_s[v.d]},     {24'd0, v.ex});
      chk({tag, " x_valid"}, {31'd0, valid_s[v.d]}, {31'd0, v.ev});
      chk({tag, " step_cnt"},{24'd0, cnt_s[v.d]},   {24'd0, v.ec});
      chk({tag, " init_q"},  {24'd0, initq_s[v.d]}, {24'd0, v.eq});
      chk({tag, " flags"},
          {28'd0, busy_s[v.d], done_s[v.d], fixed_s[v.d], timeout_s[v.d]}, {28'd0, v.fl});
      $display("row %s dut%0d ld=%0b init=%02h en=%0b -> x=%02h v=%0b cnt=%0d",
               tag, v.d, v.ld, v.ini, v.en, x_s[v.d], valid_s[v.d], cnt_s[v.d]);
   endtask

   // Scoreboard: every x_valid pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst && valid_s[k]) begin
            logic [17:0] got;
            got = {2'(k), x_s[k], cnt_s[k]};
            if (sbq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_unexpected: actual %05h required none", got);
            end else begin
               chk("sb_state", {14'd0, got}, {14'd0, sbq.pop_front()});
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
         chk($sformatf("reset_state dut%0d", k),
             {valid_s[k], x_s[k], initq_s[k], cnt_s[k], busy_s[k], done_s[k], fixed_s[k], timeout_s[k]}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Fixed point from 0x00: thermometer fill up to 0x7F.
      tbl.push_back(mk(0, 1, 8'h00, 0, 8'h00, 1, 8'd0, 8'h00, 4'b1000));
      for (int t = 1; t <= 7; t++)
         tbl.push_back(mk(0, 0, 8'h00, 1, 8'((1 << t) - 1), 1, 8'(t), 8'h00, 4'b1000));
      tbl.push_back(mk(0, 0, 8'h00, 1, 8'h7F, 0, 8'd7, 8'h00, 4'b0110));
      tbl.push_back(mk(0, 0, 8'h00, 1, 8'h7F, 0, 8'd7, 8'h00, 4'b0110));
      // Timeout with budget 3.
      tbl.push_back(mk(1, 1, 8'h00, 0, 8'h00, 1, 8'd0, 8'h00, 4'b1000));
      tbl.push_back(mk(1, 0, 8'h00, 1, 8'h01, 1, 8'd1, 8'h00, 4'b1000));
      tbl.push_back(mk(1, 0, 8'h00, 1, 8'h03, 1, 8'd2, 8'h00, 4'b1000));
      tbl.push_back(mk(1, 0, 8'h00, 1, 8'h07, 1, 8'd3, 8'h00, 4'b1000));
      tbl.push_back(mk(1, 0, 8'h00, 1, 8'h07, 0, 8'd3, 8'h00, 4'b0101));
      // Fixed point beats timeout with budget 1; then load beats a pending fixed point.
      tbl.push_back(mk(2, 1, 8'h7F, 0, 8'h7F, 1, 8'd0, 8'h7F, 4'b1000));
      tbl.push_back(mk(2, 0, 8'h00, 1, 8'h7F, 0, 8'd0, 8'h7F, 4'b0110));
      tbl.push_back(mk(2, 1, 8'h7F, 0, 8'h7F, 1, 8'd0, 8'h7F, 4'b1000));
      tbl.push_back(mk(2, 1, 8'h00, 1, 8'h00, 1, 8'd0, 8'h00, 4'b1000));
      tbl.push_back(mk(2, 0, 8'h00, 1, 8'h01, 1, 8'd1, 8'h00, 4'b1000));
      tbl.push_back(mk(2, 0, 8'h00, 1, 8'h01, 0, 8'd1, 8'h00, 4'b0101));
      // Stall from 0x80, then reload mid-run with 0x3F.
      tbl.push_back(mk(0, 1, 8'h80, 0, 8'h80, 1, 8'd0, 8'h80, 4'b1000));
      tbl.push_back(mk(0, 0, 8'h00, 1, 8'h00, 1, 8'd1, 8'h80, 4'b1000));
      tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'd1, 8'h80, 4'b1000));
      tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'd1, 8'h80, 4'b1000));
      tbl.push_back(mk(0, 0, 8'h00, 1, 8'h01, 1, 8'd2, 8'h80, 4'b1000));
      tbl.push_back(mk(0, 0, 8'h00, 1, 8'h03, 1, 8'd3, 8'h80, 4'b1000));
      tbl.push_back(mk(0, 0, 8'h00, 1, 8'h07, 1, 8'd4, 8'h80, 4'b1000));
      tbl.push_back(mk(0, 1, 8'h3F, 1, 8'h3F, 1, 8'd0, 8'h3F, 4'b1000));
      tbl.push_back(mk(0, 0, 8'h00, 1, 8'h7F, 1, 8'd1, 8'h3F, 4'b1000));
      tbl.push_back(mk(0, 0, 8'h00, 1, 8'h7F, 0, 8'd1, 8'h3F, 4'b0110));
      // Lead-in for the asynchronous reset check.
      tbl.push_back(mk(0, 1, 8'h00, 0, 8'h00, 1, 8'd0, 8'h00, 4'b1000));
      tbl.push_back(mk(0, 0, 8'h00, 1, 8'h01, 1, 8'd1, 8'h00, 4'b1000));
      tbl.push_back(mk(0, 0, 8'h00, 1, 8'h03, 1, 8'd2, 8'h00, 4'b1000));

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("%0d", i));

      // Reset asserted mid-run between clock edges must clear outputs immediately.
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++)
         chk($sformatf("async_reset dut%0d", k),
             {valid_s[k], x_s[k], initq_s[k], cnt_s[k], busy_s[k], done_s[k], fixed_s[k], timeout_s[k]}, 32'd0);
      $display("async reset mid-run -> dut0 x=%02h busy=%0b", x_s[0], busy_s[0]);
      #2;
      rst = 1'b1;
      en_s[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("idle_no_valid c%0d", c),
             {29'd0, valid_s[0], valid_s[1], valid_s[2]}, 32'd0);
         chk($sformatf("idle_not_busy c%0d", c), {31'd0, busy_s[0]}, 32'd0);
      end
      clear_inputs();
      @(negedge clk);

      chk("sb_drained", sbq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gene_step.md
# gene_step

Synchronous 8-gene Boolean network stepper. Latches an initial gene state, then applies the network update rule once per enabled clock to produce the trajectory x[0], x[1], x[2], … It stops on a fixed point or after a step budget. It sits directly upstream of the period-2 cycle detector: `x` drives the detector's state input, and `init_q` drives its 8-bit init/restart input.

## Interface
- `MAX_STEPS`, default 255: largest step index produced before timeout; range 1..255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `init` in 8: initial gene state, sampled on `load`.
- `load` in 1: start/restart pulse; highest priority in every state.
- `step_en` in 1: advance enable while running; low = stall.
- `x` out 8: current gene state x[t].
- `x_valid` out 1: one-cycle pulse, `x` holds a newly produced state.
- `init_q` out 8: latched initial state; changes only on `load`.
- `step_cnt` out 8: index t of the state on `x`.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE; held until next `load`.
- `fixed` out 1: DONE reached via fixed point.
- `timeout` out 1: DONE reached via step budget.

## Operation
- Update rule (combinational, `n = f(x)`):
  - n[0] = ~x[7]
  - n[i] = x[i-1] for i = 1..6
  - n[7] = x[6] & ~x[3]
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- Any state, `load`=1: `x`←`init`, `init_q`←`init`, `step_cnt`←0, `x_valid`←1, `fixed`/`timeout`/`done`←0, state←RUN.
- RUN, `load`=0, `step_en`=0: hold everything; `x_valid`←0.
- RUN, `step_en`=1, evaluated in this order:
  - `f(x)`==`x`: `fixed`←1, `done`←1, state←DONE, `x_valid`←0; `x` and `step_cnt` unchanged.
  - else `step_cnt`==`MAX_STEPS`: `timeout`←1, `done`←1, state←DONE, `x_valid`←0.
  - else `x`←`f(x)`, `step_cnt`←`step_cnt`+1, `x_valid`←1.
- Fixed-point check has priority over timeout in the same cycle.
- IDLE/DONE with `load`=0: outputs hold; `x_valid`=0; `step_en` ignored.
- `step_cnt` never wraps; `MAX_STEPS` bounds it.

## Timing
- All outputs are registered.
- Reset values: `x`=0, `init_q`=0, `step_cnt`=0, `x_valid`=0, `busy`=0, `done`=0, `fixed`=0, `timeout`=0.
- Reset asserted mid-RUN: immediate return to IDLE with reset values. Deassertion is synchronised by the top level.
- Latency: `load` sampled at edge k → x[0] visible with `x_valid`=1 after edge k.
- Each enabled edge yields the next state one cycle later; throughput is 1 state/clock.
- `done`/`fixed`/`timeout` rise one edge after the last valid state was presented, i.e. on the first enabled edge that cannot advance.
- `load` coincident with any termination condition: `load` wins.
- `init_q` updates on the same edge as `x`, so downstream restart and the first state are aligned.
- `busy` = (state==RUN), registered alongside the state.

## Structure
- Shared package `gene_pkg`:
  - `GENE_W`=8.
  - State encoding constants `S_IDLE`, `S_RUN`, `S_DONE`.
  - Rule function description. The rule set is shared with any future network variants.
- Sub-module `gene_rule`: purely combinational, 8-bit `x` in, 8-bit `n` out. Instantiated once.
- `gene_step` holds the FSM, state register, counter and flags.

## Test plan
- Reset: assert `rst`=0 mid-run → all outputs 0 immediately. Release, idle 5 clocks → `x_valid` never pulses.
- Fixed point: `init`=0x00, `load` pulse, `step_en`=1 → `x_valid` sequence 00,01,03,07,0F,1F,3F,7F with `step_cnt` 0..7. Next edge gives `done`=`fixed`=1, `x`=0x7F, `step_cnt`=7.
- Timeout: `MAX_STEPS`=3, `init`=0x00 → states 00,01,03,07. Then `done`=`timeout`=1, `fixed`=0, `step_cnt`=3.
- Stall: `init`=0x80, `step_en` toggled 1,0,0,1 → x=80 (t0), 00 (t1), held 2 cycles with `x_valid`=0, then 01 (t2).
- Reload mid-run: after x reaches 0x07, `load` with `init`=0x3F → `init_q`=0x3F, x=3F/`step_cnt`=0. Next states 7F, then `fixed`=1.
- Priority: `init`=0x7F with `MAX_STEPS`=1 → x=7F at t0. First enabled edge gives `fixed`=1, `timeout`=0.
